dispatch_queue: RTL
===================

# dispatch_queue

Parametrised decode-to-execute dispatch buffer. It replaces the single ID/EX register slot with a DEPTH-entry FIFO of decoded instruction bundles, and generalises the fixed MUL/DIV/FPU side channels to N_FU auxiliary-unit handshakes. It sits between the instruction decoder and the EX stage. It decouples decode from EX back-pressure without a combinational ready path from EX to IF.

## Interface
- DATA_WIDTH, 160: width of the decoded bundle payload (PC, IR, immediate, operands, control fields).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- N_FU, 3: number of auxiliary functional-unit channels.
- CW, $clog2(DEPTH+1): count width (derived, not overridable).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- valid_in  in  1  decoder offers a bundle.
- ready_out  out  1  queue can accept a bundle.
- data_in  in  DATA_WIDTH  bundle payload.
- fu_sel_in  in  N_FU  per-unit request mask for the bundle; 0 means main pipe only.
- valid_out  out  1  head bundle is ready for EX.
- ready_in  in  1  EX accepts the head bundle.
- data_out  out  DATA_WIDTH  head payload; 0 when the queue is empty.
- valid_out_fu  out  N_FU  per-unit head offer.
- ready_in_fu  in  N_FU  per-unit acceptance.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×(DATA_WIDTH+N_FU) array, with write pointer wr_ptr and read pointer rd_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy counter is a separate register.
  - The array is not reset.
- Push: valid_in && ready_out && !flush. Writes {fu_sel_in, data_in} to mem[wr_ptr] and increments wr_ptr.
- ready_out = (count < DEPTH). It does not depend on ready_in, so a full queue refuses a push even when a pop happens in the same cycle.
- Head: not_empty = (count != 0); sel = stored mask of the head entry.
- done register, N_FU bits, tracks which requested units have already accepted the head.
- Per-unit offer: valid_out_fu[i] = not_empty && sel[i] && !done[i] && !flush.
- Per-unit handshake: valid_out_fu[i] && ready_in_fu[i] sets done[i] at the next edge. Each unit sees the head exactly once.
- Main offer: valid_out = not_empty && ((sel & ~done) == 0) && !flush. EX only receives a bundle after every requested unit has captured its operands.
- Pop: valid_out && ready_in. Increments rd_ptr and clears done to 0.
- count update: push and pop together leave count unchanged; push alone adds 1; pop alone subtracts 1.
- Flush: at the edge, count, rd_ptr, wr_ptr and done go to 0. A push offered in the same cycle is dropped. All valid outputs are gated low combinationally during the flush cycle.
- Reset: same as flush, and takes priority over flush.
- Multi-bit fu_sel_in is legal. Each selected unit is offered independently, in any order; the bundle goes to EX only when all have accepted.

## Timing
- Reset values:
  - count = 0, ready_out = 1.
  - valid_out = 0, valid_out_fu = 0, data_out = 0.
  - Internal pointers and done = 0.
- Push-to-head latency is 1 cycle, with no bypass. A bundle pushed at edge n is visible on data_out and valid_out or valid_out_fu from cycle n+1 on.
- Main-pipe-only bundle: valid_out rises in cycle n+1.
- FU bundle: valid_out_fu rises in cycle n+1. The earliest valid_out is the cycle after the last FU handshake.
- Throughput: one bundle per cycle for main-only traffic with ready_in held high. An FU bundle costs at least 2 cycles at the head.
- Full: with count = DEPTH, ready_out = 0, and push with valid_in high has no effect.
- Empty: with count = 0, valid_out = 0, valid_out_fu = 0 and data_out = 0, whatever the ready inputs are.
- Wrap: after DEPTH pushes, wr_ptr returns to 0; ordering is strictly FIFO across the wrap.
- ready_in_fu[i] is ignored when sel[i] = 0 or done[i] = 1.

## Test plan
- Reset, then push A (fu_sel 0), B, C with ready_in held 0. Required: count reaches 3 and valid_out = 1 with data_out = A. Then set ready_in = 1: A, B, C come out on consecutive cycles and count ends at 0.
- DEPTH = 4: push 5 bundles with ready_in = 0. Required: ready_out drops after the 4th and the 5th is not stored. Then pop all: 4 bundles come out in order.
- Push D with fu_sel = 3'b010 while ready_in_fu is held 0. Required: valid_out_fu = 3'b010 and valid_out = 0. Pulse ready_in_fu[1] for one cycle: valid_out_fu returns to 0 and valid_out = 1 on the next cycle.
- Push E with fu_sel = 3'b101. Accept unit 2 first, then unit 0 three cycles later. Required: valid_out_fu[2] drops after its handshake, and valid_out rises only after the unit 0 handshake.
- With 3 entries queued and the head's FU already done, assert flush together with valid_in. Required: all valid outputs are 0 in that cycle, and count = 0 with data_out = 0 next cycle. The next push comes out first.
- Run 3×DEPTH random push/pop operations with an incrementing payload. Required: output sequence equals input sequence across pointer wrap, and count always equals pushes minus pops.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: DEPTH-entry decode-to-EX FIFO with N_FU auxiliary-unit handshakes at the head
module dispatch_queue #(
  parameter int DATA_WIDTH = 160,
  parameter int DEPTH = 4,
  parameter int N_FU = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [N_FU-1:0]       fu_sel_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [N_FU-1:0]       valid_out_fu,
  input  logic [N_FU-1:0]       ready_in_fu,
  output logic [CW-1:0]         count
);
  localparam int PW = $clog2(DEPTH);
  logic [N_FU+DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [N_FU-1:0] done, sel, pending;
  logic not_empty, push, pop;
  always_comb begin
    not_empty = count != '0;
    sel = mem[rd_ptr][N_FU+DATA_WIDTH-1:DATA_WIDTH];
    pending = sel & ~done;
    ready_out = count < CW'(DEPTH);
    data_out = not_empty ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    valid_out_fu = (not_empty && !flush) ? pending : '0;
    valid_out = not_empty && !flush && pending == '0;
    push = valid_in && ready_out && !flush;
    pop = valid_out && ready_in;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fu_sel_in, data_in};
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      done <= pop ? '0 : done | (valid_out_fu & ready_in_fu);
    end
  end
endmodule
